// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates an instruction-fetch port and a
// load/store port onto a single 8-bit synchronous RAM interface.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din
);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    localparam logic LG_IF = 1'b0;
    localparam logic LG_LS = 1'b1;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [2:0] i);
        case (i)
            3'd0:    byte_of = w[7:0];
            3'd1:    byte_of = w[15:8];
            3'd2:    byte_of = w[23:16];
            default: byte_of = w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [2:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (i)
            3'd0:    r[7:0]   = b;
            3'd1:    r[15:8]  = b;
            3'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] size_n(input logic [1:0] s);
        case (s)
            2'd0:    size_n = 3'd1;
            2'd1:    size_n = 3'd2;
            default: size_n = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [2:0] n);
        case (n)
            3'd1:    size_mask = 32'h0000_00FF;
            3'd2:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic        lg_q, lg_d;
    logic        stall_q, stall_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        if_vld;
    logic        can_accept;
    logic        grant_ls;
    logic        grant_if;
    logic [2:0]  cnt_inc;
    logic [31:0] a_next;
    logic [31:0] buf_ins;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        lg_d       = lg_q;
        stall_d    = stall_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = mem_wr_q;
        mem_dout_d = mem_dout_q;
        if_done_d  = if_done_q;
        if_data_d  = if_data_q;
        ls_done_d  = ls_done_q;
        ls_rdata_d = ls_rdata_q;

        if_vld     = if_req && !if_flush;
        can_accept = (state_q == IDLE) && !if_done_q && !ls_done_q;
        grant_ls   = ls_req && (!if_vld || (lg_q == LG_IF));
        grant_if   = if_vld && !grant_ls;
        cnt_inc    = cnt_q + 3'd1;
        a_next     = base_q + {29'd0, cnt_inc};
        // mem_din carries the byte addressed during the previous cycle
        buf_ins    = (cnt_q != 3'd0) ? put_byte(buf_q, cnt_q - 3'd1, mem_din) : buf_q;

        if (!rdy) begin
            // Everything holds; the stall flag tells the resume cycle what to redo
            mem_wr_d = 1'b0;
            if (state_q != IDLE) stall_d = 1'b1;
        end else begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (can_accept && (grant_ls || grant_if)) begin
                        base_d  = grant_ls ? ls_addr : if_addr;
                        mem_a_d = grant_ls ? ls_addr : if_addr;
                        n_d     = grant_ls ? size_n(ls_size) : 3'd4;
                        wdata_d = ls_wdata;
                        buf_d   = '0;
                        cnt_d   = 3'd0;
                        lg_d    = grant_ls ? LG_LS : LG_IF;
                        if (grant_ls && ls_we) begin
                            state_d    = LS_WR;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = ls_wdata[7:0];
                        end else begin
                            state_d    = grant_ls ? LS_RD : IF_RD;
                            mem_wr_d   = 1'b0;
                            mem_dout_d = 8'd0;
                        end
                    end
                end
                IF_RD, LS_RD: begin
                    mem_wr_d   = 1'b0;
                    mem_dout_d = 8'd0;
                    if ((state_q == IF_RD) && if_flush) begin
                        state_d = IDLE;
                        stall_d = 1'b0;
                    end else if (stall_q) begin
                        // Bytes in flight during the stall are lost; start over
                        stall_d = 1'b0;
                        cnt_d   = 3'd0;
                        mem_a_d = base_q;
                    end else begin
                        buf_d = buf_ins;
                        if (cnt_q == n_q) begin
                            state_d = IDLE;
                            if (state_q == IF_RD) begin
                                if_done_d = 1'b1;
                                if_data_d = buf_ins;
                            end else begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = buf_ins & size_mask(n_q);
                            end
                        end else begin
                            cnt_d   = cnt_inc;
                            mem_a_d = a_next;
                        end
                    end
                end
                LS_WR: begin
                    if (stall_q) begin
                        // Re-issue the byte at the frozen count
                        stall_d  = 1'b0;
                        mem_wr_d = 1'b1;
                    end else if (cnt_q == (n_q - 3'd1)) begin
                        state_d    = IDLE;
                        ls_done_d  = 1'b1;
                        mem_wr_d   = 1'b0;
                        mem_dout_d = 8'd0;
                    end else begin
                        cnt_d      = cnt_inc;
                        mem_a_d    = a_next;
                        mem_dout_d = byte_of(wdata_q, cnt_inc);
                        mem_wr_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            lg_q       <= LG_IF;
            stall_q    <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= 8'd0;
            if_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lg_q       <= lg_d;
            stall_q    <= stall_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Transaction operands are always written at grant before use
    always_ff @(posedge clk) begin
        base_q  <= base_d;
        n_q     <= n_d;
        wdata_q <= wdata_d;
        buf_q   <= buf_d;
    end

    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of single transactions plus
// hand-written arbitration, flush, stall, wrap and reset sequences.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_req, if_flush, ls_req, ls_we;
    logic [1:0]  ls_size;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_done, ls_done, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_dout, mem_din;

    logic [7:0]  ram [0:4095];
    logic [31:0] tr_a [0:3];
    logic        stall_wr_bad;
    int          errs = 0;
    int          checks = 0;

    typedef struct {
        logic        is_if;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_d;
        logic [31:0] exp_d;
        int          exp_lat;
    } vec_t;

    vec_t vt [14];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency, 4 KB mirror of the address space
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got running want finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic txn(input logic is_if, input logic we, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int rdy_at, input int rdy_n,
                       output int lat, output logic [31:0] data, output logic wrong);
        @(negedge clk);
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wdata;
        end
        lat = -1; data = 32'd0; wrong = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if_req = 1'b0; ls_req = 1'b0;
            if (k <= 4) tr_a[k-1] = mem_a;
            if (!rdy && mem_wr) stall_wr_bad = 1'b1;
            if (is_if ? ls_done : if_done) wrong = 1'b1;
            if (is_if ? if_done : ls_done) begin
                lat = k;
                data = is_if ? if_data : ls_rdata;
            end
            rdy = (rdy_at > 0 && k >= rdy_at && k < rdy_at + rdy_n) ? 1'b0 : 1'b1;
        end
        rdy = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int          lat, lsk, nev;
        logic [31:0] d;
        logic        wrong, ifd, bad;
        int          ev_k [8];
        logic        ev_ls [8];

        rst = 1'b0; rdy = 1'b1;
        if_req = 1'b0; if_flush = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        stall_wr_bad = 1'b0;
        for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05; ram[12'h102] <= 8'hA0; ram[12'h103] <= 8'h00;
        ram[12'h040] <= 8'h11; ram[12'h041] <= 8'h22; ram[12'h042] <= 8'h33; ram[12'h043] <= 8'h44;
        ram[12'hFFE] <= 8'hAA; ram[12'hFFF] <= 8'hBB; ram[12'h000] <= 8'hCC; ram[12'h001] <= 8'hDD;

        vt[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         1'b1, 32'h00A0_0513, 6};
        vt[1]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0021, 32'h0,         1'b1, 32'h0000_00BE, 3};
        vt[2]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_BEEF, 4};
        vt[3]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'h0,         1'b1, 32'h4433_2211, 6};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0043, 32'h0,         1'b1, 32'h0000_0044, 3};
        vt[5]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0050, 32'hCAFE_F00D, 1'b0, 32'h0,         5};
        vt[6]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0050, 32'h0,         1'b1, 32'hCAFE_F00D, 6};
        vt[7]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0060, 32'h1234_5678, 1'b0, 32'h0,         2};
        vt[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0060, 32'h0,         1'b1, 32'h0000_0078, 6};
        vt[9]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0040, 32'h0,         1'b1, 32'h4433_2211, 6};
        vt[10] = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0000_CCBB, 4};
        vt[11] = '{1'b1, 1'b0, 2'd0, 32'h0000_0040, 32'h0,         1'b1, 32'h4433_2211, 6};
        vt[12] = '{1'b0, 1'b1, 2'd1, 32'h0000_0064, 32'h0000_A5C3, 1'b0, 32'h0,         3};
        vt[13] = '{1'b0, 1'b0, 2'd1, 32'h0000_0064, 32'h0,         1'b1, 32'h0000_A5C3, 4};

        // Outputs while reset is held
        repeat (2) @(negedge clk);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_ls_done", {31'd0, ls_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        rst = 1'b1;

        // Half store at 0x20: two bytes written, latency 3
        txn(1'b0, 1'b1, 2'd1, 32'h20, 32'hDEAD_BEEF, 0, 0, lat, d, wrong);
        chk("st_half_lat", lat, 32'd3);
        chk("st_half_b0", {24'd0, ram[12'h020]}, 32'hEF);
        chk("st_half_b1", {24'd0, ram[12'h021]}, 32'hBE);
        chk("st_half_b2", {24'd0, ram[12'h022]}, 32'h00);

        for (int i = 0; i < 14; i++) begin
            txn(vt[i].is_if, vt[i].we, vt[i].sz, vt[i].addr, vt[i].wdata, 0, 0, lat, d, wrong);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d_other_done", i), {31'd0, wrong}, 32'd0);
            if (vt[i].chk_d) chk($sformatf("vec%0d_data", i), d, vt[i].exp_d);
        end

        // Address sequences: plain fetch and wrapping word load
        txn(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, 0, 0, lat, d, wrong);
        for (int i = 0; i < 4; i++) chk($sformatf("fetch_a%0d", i), tr_a[i], 32'h100 + i);
        txn(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0, 0, lat, d, wrong);
        chk("wrap_a0", tr_a[0], 32'hFFFF_FFFE);
        chk("wrap_a1", tr_a[1], 32'hFFFF_FFFF);
        chk("wrap_a2", tr_a[2], 32'h0000_0000);
        chk("wrap_a3", tr_a[3], 32'h0000_0001);
        chk("wrap_data", d, 32'hDDCC_BBAA);

        // Flush at fetch cnt=2 with a load pending behind it
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        ifd = 1'b0; lsk = -1; d = 32'd0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (if_done) ifd = 1'b1;
            if (ls_done && lsk < 0) begin lsk = k; d = ls_rdata; end
            if (k == 1) begin
                if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h43;
            end
            if (k == 5) ls_req = 1'b0;
            if_flush = (k == 3);
        end
        chk("flush_no_if_done", {31'd0, ifd}, 32'd0);
        chk("flush_ls_done_cycle", lsk, 32'd7);
        chk("flush_ls_data", d, 32'h44);

        // Read stalled three cycles at cnt=2 restarts and returns correct data
        stall_wr_bad = 1'b0;
        txn(1'b0, 1'b0, 2'd2, 32'h40, 32'h0, 3, 3, lat, d, wrong);
        chk("stall_rd_done", {31'd0, lat > 0}, 32'd1);
        chk("stall_rd_data", d, 32'h4433_2211);
        chk("stall_rd_wr", {31'd0, stall_wr_bad}, 32'd0);

        // Write stalled at cnt=1 resumes and completes
        stall_wr_bad = 1'b0;
        txn(1'b0, 1'b1, 2'd2, 32'h80, 32'h0BAD_F00D, 2, 2, lat, d, wrong);
        chk("stall_wr_done", {31'd0, lat > 0}, 32'd1);
        chk("stall_wr_wr_low", {31'd0, stall_wr_bad}, 32'd0);
        chk("stall_wr_word", {ram[12'h083], ram[12'h082], ram[12'h081], ram[12'h080]}, 32'h0BAD_F00D);

        // Reset during a word store at cnt=1
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h70; ls_wdata = 32'hA1B2_C3D4;
        @(negedge clk);
        ls_req = 1'b0;
        @(negedge clk);
        chk("rstw_active", {31'd0, mem_wr}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstw_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rstw_mem_a", mem_a, 32'd0);
        chk("rstw_mem_dout", {24'd0, mem_dout}, 32'd0);
        bad = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ls_done) bad = 1'b1;
        end
        chk("rstw_no_done", {31'd0, bad}, 32'd0);
        chk("rstw_b0_kept", {24'd0, ram[12'h070]}, 32'hD4);
        chk("rstw_b1_none", {24'd0, ram[12'h071]}, 32'h00);

        // Both requests held from reset: ls, if, ls, if, one idle done-cycle apart
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h40;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nev = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if ((ls_done || if_done) && nev < 8) begin
                ev_k[nev] = k; ev_ls[nev] = ls_done; nev++;
                if (if_done) chk("arb_if_data", if_data, 32'h00A0_0513);
                if (ls_done) chk("arb_ls_data", ls_rdata, 32'h4433_2211);
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("arb_count", nev, 32'd4);
        if (nev >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("arb%0d_is_ls", i), {31'd0, ev_ls[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("arb%0d_cycle", i), ev_k[i], 6 + 7 * i);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
